// File: rtl/regfile_xor_mp_if.sv
// Bus bundle for regfile_xor_mp: two write ports, NR packed read ports, status flags.
// Writes are qualified only by we1/we2 (no ready); they are silently dropped while busy is high.
interface regfile_xor_mp_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NR   = 4
);
  logic               we1;
  logic               we2;
  logic [AW-1:0]      w_addr1;
  logic [AW-1:0]      w_addr2;
  logic [XLEN-1:0]    w_data1;
  logic [XLEN-1:0]    w_data2;
  logic [NR*AW-1:0]   r_addr;
  logic [NR*XLEN-1:0] r_data;
  logic               busy;
  logic               wr_conflict;

  modport master (
    output we1, we2, w_addr1, w_addr2, w_data1, w_data2, r_addr,
    input  r_data, busy, wr_conflict
  );

  modport slave (
    input  we1, we2, w_addr1, w_addr2, w_data1, w_data2, r_addr,
    output r_data, busy, wr_conflict
  );
endinterface

// File: rtl/regfile_xor_mp.sv
// Two-write, NR-read register file from two XOR-coded banks with a post-reset clear sweep.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_xor_mp #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int NR       = 4,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  regfile_xor_mp_if.slave  rf,
  output logic             fsm_state
);
  localparam int            DEPTH    = 1 << AW;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t          state;
  state_t          state_next;
  logic [AW-1:0]   clr_ptr;
  logic            busy_int;

  logic [XLEN-1:0] bank_a [DEPTH];
  logic [XLEN-1:0] bank_b [DEPTH];

  logic            drop1;
  logic            drop2;
  logic            same_addr;
  logic            conflict;
  logic            wen1;
  logic            wen2;
  logic            conflict_q;

  logic [AW-1:0]     rd_a;
  logic [XLEN-1:0]   rd_v;
  logic [NR*XLEN-1:0] r_data_c;

  // State register and clear pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) clr_ptr <= clr_ptr + PTR_ONE;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clr_ptr == PTR_LAST) state_next = READY;
      READY:   state_next = READY;
      default: state_next = CLEAR;
    endcase
  end

  always_comb begin
    busy_int  = (state == CLEAR);
    fsm_state = state;
  end

  // Port 1 wins a same-address collision; port 2 is suppressed entirely.
  always_comb begin
    drop1     = (ZERO_REG != 0) && (rf.w_addr1 == '0);
    drop2     = (ZERO_REG != 0) && (rf.w_addr2 == '0);
    same_addr = (rf.w_addr1 == rf.w_addr2);
    wen1      = rf.we1 && !busy_int && !drop1;
    conflict  = wen1 && rf.we2 && same_addr;
    wen2      = rf.we2 && !busy_int && !drop2 && !conflict;
  end

  // Each bank stores data XOR the other bank's entry so A^B yields the last write.
  always_ff @(posedge clk) begin
    if (busy_int) begin
      bank_a[clr_ptr] <= '0;
    end else if (wen1) begin
      bank_a[rf.w_addr1] <= rf.w_data1 ^ bank_b[rf.w_addr1];
    end
  end

  always_ff @(posedge clk) begin
    if (busy_int) begin
      bank_b[clr_ptr] <= '0;
    end else if (wen2) begin
      bank_b[rf.w_addr2] <= rf.w_data2 ^ bank_a[rf.w_addr2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) conflict_q <= 1'b0;
    else     conflict_q <= conflict;
  end

  always_comb begin
    r_data_c = '0;
    rd_a     = '0;
    rd_v     = '0;
    for (int k = 0; k < NR; k++) begin
      rd_a = rf.r_addr[k*AW +: AW];
      rd_v = bank_a[rd_a] ^ bank_b[rd_a];
`ifdef REGFILE_BYPASS_EN
      if (wen1 && (rd_a == rf.w_addr1)) rd_v = rf.w_data1;
      else if (wen2 && (rd_a == rf.w_addr2)) rd_v = rf.w_data2;
`else
`endif
      if (busy_int || ((ZERO_REG != 0) && (rd_a == '0))) rd_v = '0;
      r_data_c[k*XLEN +: XLEN] = rd_v;
    end
  end

  assign rf.r_data      = r_data_c;
  assign rf.busy        = busy_int;
  assign rf.wr_conflict = conflict_q;
endmodule

// File: doc/regfile_xor_mp.md
# regfile_xor_mp

Parametrised two-write, N-read register file built from two XOR-coded distributed-RAM banks, the successor to the fixed 32x32 four-read integer register file in the core's decode/writeback path. Adds configurable width, depth and read-port count, an optional hardwired-zero entry, a synchronous clear sequencer that zeroes every entry after reset, same-address write-conflict arbitration, and compile-time write-to-read bypass. Read and write behaviour are single-cycle, so the core's issue logic sees the same timing as before once `busy` is low.

## Interface
Parameters:
- `XLEN`, 32, data width of each entry.
- `AW`, 5, address width; `DEPTH` = 2**AW entries.
- `NR`, 4, number of read ports (>= 1).
- `ZERO_REG`, 1, 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is an ordinary register.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset; starts the clear sequence.
- `we1`, `we2`  in  1  write enables, port 1 and port 2.
- `w_addr1`, `w_addr2`  in  AW  write addresses.
- `w_data1`, `w_data2`  in  XLEN  write data.
- `r_addr`  in  NR*AW  read addresses; port k occupies bits [k*AW +: AW].
- `r_data`  out  NR*XLEN  read data; port k occupies bits [k*XLEN +: XLEN].
- `busy`  out  1  high while the clear sequence runs; writes are ignored and reads return 0.
- `wr_conflict`  out  1  one-cycle registered pulse: the previous cycle had a same-address dual write.

## Operation
- Storage: bank A is written by port 1, bank B by port 2, each DEPTH x XLEN.
- Port 1 write: A[w_addr1] <= w_data1 ^ B[w_addr1]. Port 2 write: B[w_addr2] <= w_data2 ^ A[w_addr2]. Both use pre-edge bank contents.
- Read: r_data[k] = A[a] ^ B[a], where a = r_addr[k]. This value is forced to 0 when `busy` is high, or when ZERO_REG=1 and a = 0.
- FSM has two states, CLEAR and READY.
  - `rst` high: the next state is CLEAR and the counter `clr_ptr` is set to 0, whatever the current state, including mid-clear.
  - CLEAR: each cycle, A[clr_ptr] <= 0 and B[clr_ptr] <= 0, then clr_ptr increments. After writing entry DEPTH-1, the next state is READY.
  - READY: normal operation. Stays in READY until `rst`.
- `we1`/`we2` are ignored in CLEAR, and no conflict is flagged there.
- Zero entry: with ZERO_REG=1, writes to address 0 are dropped and are not counted as a conflict.
- Conflict: we1 & we2 & (w_addr1 == w_addr2) in READY, on a non-dropped address.
  - Port 1 wins. Its write is A[a] <= w_data1 ^ B[a].
  - Port 2's write is suppressed.
  - `wr_conflict` = 1 for exactly the following cycle.
- Different addresses: both writes complete in the same cycle.

## Timing
- Reset values: `busy` = 1 and `wr_conflict` = 0 in the cycle after the `rst` edge.
- `busy` stays high for DEPTH cycles after the last edge sampling `rst` = 1. It is low from the edge that completes entry DEPTH-1.
- Read latency is 0 (combinational). A write is visible on reads in the cycle after its edge.
- Same-cycle read of an address being written returns the old value, unless the bypass is enabled (see Configuration).
- `wr_conflict` has 1-cycle latency and is not sticky. Back-to-back conflicts give a continuous high.
- Holding `rst` high keeps the block in CLEAR with clr_ptr = 0.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - A read port whose address equals an active, non-dropped write address in the same cycle returns that write's data combinationally.
  - On a conflict, port 1's data is returned.
  - Bypass is inactive while `busy` is high and for address 0 when ZERO_REG=1.
- `REGFILE_BYPASS_EN` undefined: no forwarding, and reads return pre-edge contents.

## Test plan
- Reset sweep: pulse `rst` for 1 cycle with DEPTH=32.
  - Required: `busy` is high for 32 cycles then low, and all 32 entries read 0 on every port.
  - With `we1` = 1 during the sweep: no effect.
- Dual write, different addresses: we1 = we2 = 1, addr 3 <- 0xDEADBEEF, addr 7 <- 0x12345678.
  - Required next cycle: ports 0..3 reading 3/7/3/7 return those values.
  - Required: `wr_conflict` = 0.
- Conflict: we1 = we2 = 1, both to addr 9, data 0xAAAA5555 and 0x0F0F0F0F.
  - Required: addr 9 reads 0xAAAA5555.
  - Required: `wr_conflict` is high for exactly 1 cycle.
- Zero register, ZERO_REG=1: write 0xFFFFFFFF to addr 0 on both ports.
  - Required: reads 0 and `wr_conflict` = 0.
  - Repeat with ZERO_REG=0: reads 0xFFFFFFFF.
- Reset mid-clear: assert `rst` at clr_ptr = 20 after writes to addr 25.
  - Required: `busy` stays high 32 more cycles and addr 25 reads 0 afterwards.
- Bypass: write 0x00C0FFEE to addr 4 while reading addr 4 in the same cycle.
  - With `REGFILE_BYPASS_EN`: same-cycle read returns 0x00C0FFEE.
  - Without it: same-cycle read returns the prior value.
